// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART APB register front-end.
//   reg_idx_e   - APB word index (padd[4:2]) of each register
//   CTRL_*      - CTRL register bit positions
//   IRQ_*       - IRQ_STAT / IRQ_EN bit positions
//   ST_*        - STATUS register field offsets
//   RX_*_BIT    - error flag positions in the RXDATA read word
package uart_pkg;

  typedef enum logic [2:0] {
    REG_TXDATA   = 3'd0,
    REG_RXDATA   = 3'd1,
    REG_STATUS   = 3'd2,
    REG_CTRL     = 3'd3,
    REG_IRQ_STAT = 3'd4,
    REG_IRQ_EN   = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_RX_EN    = 1;
  localparam int unsigned CTRL_TX_FLUSH = 2;
  localparam int unsigned CTRL_RX_FLUSH = 3;

  localparam int unsigned IRQ_TX_EMPTY  = 0;
  localparam int unsigned IRQ_RX_THRESH = 1;
  localparam int unsigned IRQ_TX_OVF    = 2;
  localparam int unsigned IRQ_RX_OVR    = 3;
  localparam int unsigned IRQ_RX_ERR    = 4;
  localparam int unsigned IRQ_W         = 5;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_TX_COUNT = 8;
  localparam int unsigned ST_RX_COUNT = 16;

  localparam int unsigned RX_PAR_BIT = 16;
  localparam int unsigned RX_FRM_BIT = 17;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush.
//   clk, rst       - clock, asynchronous active-low reset
//   push, wdata    - write request and data
//   pop            - read request; rdata is the current head (first-word fall-through)
//   flush          - empties the FIFO on this edge, overriding push/pop
//   full, empty    - status flags
//   count          - number of stored entries (0..DEPTH)
module uart_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = count[AW];

endmodule

// File: rtl/uart_apb_fifo_slave.sv
// uart_apb_fifo_slave: APB register front-end for a UART with TX and RX FIFOs.
//   clk, rst                 - clock, asynchronous active-low reset
//   padd/pdata/psel/pen/pwr  - APB request (word index padd[4:2])
//   PSTRB                    - write byte strobes
//   prdata/PREADY/PSLVERR    - APB response (zero wait states)
//   txStart/txData/txAck     - TX FIFO head offered to the tx engine; txAck pops it
//   rxValid/rxData           - received character pushed into the RX FIFO
//   rxParErr/rxFrmErr        - error flags stored with the received character
//   irq                      - level interrupt, |(IRQ_STAT & IRQ_EN)
module uart_apb_fifo_slave
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned RX_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       padd,
  input  logic [31:0]       pdata,
  input  logic              psel,
  input  logic              pen,
  input  logic              pwr,
  input  logic [3:0]        PSTRB,
  output logic [31:0]       prdata,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              txStart,
  output logic [DATA_W-1:0] txData,
  input  logic              txAck,
  input  logic              rxValid,
  input  logic [DATA_W-1:0] rxData,
  input  logic              rxParErr,
  input  logic              rxFrmErr,
  output logic              irq
);

  localparam int unsigned TXC = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXC = $clog2(RX_DEPTH) + 1;

  reg_idx_e          idx;
  logic              access, illegal, rd_ok, wr_ok;
  logic [1:0]        ctrl_q;
  logic [IRQ_W-1:0]  irq_en_q, irq_stat;
  logic              ovf_q, ovr_q, err_q;
  logic              ctrl_wr, stat_wr;
  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [TXC-1:0]    tx_count;
  logic [RXC-1:0]    rx_count;
  logic [DATA_W+1:0] rx_head;
  logic              tx_strb_ok;

  assign idx    = reg_idx_e'(padd[4:2]);
  assign access = psel & pen;

  always_comb begin
    illegal = 1'b0;
    case (idx)
      REG_RSVD6, REG_RSVD7:   illegal = 1'b1;
      REG_TXDATA:             illegal = ~pwr;
      REG_RXDATA, REG_STATUS: illegal = pwr;
      default:                illegal = 1'b0;
    endcase
  end

  assign rd_ok   = access & ~illegal & ~pwr;
  assign wr_ok   = access & ~illegal & pwr;
  assign PREADY  = access & rst;
  assign PSLVERR = access & illegal & rst;

  // A 9-bit character spans two byte lanes, so both strobes are needed.
  assign tx_strb_ok = PSTRB[0] & (PSTRB[1] | (DATA_W <= 8));
  assign tx_push    = wr_ok & (idx == REG_TXDATA) & tx_strb_ok;
  assign tx_pop     = txAck & txStart;
  assign ctrl_wr    = wr_ok & (idx == REG_CTRL) & PSTRB[0];
  assign stat_wr    = wr_ok & (idx == REG_IRQ_STAT) & PSTRB[0];
  assign tx_flush   = ctrl_wr & pdata[CTRL_TX_FLUSH];
  assign rx_flush   = ctrl_wr & pdata[CTRL_RX_FLUSH];
  assign rx_push    = rxValid & ctrl_q[CTRL_RX_EN];
  assign rx_pop     = rd_ok & (idx == REG_RXDATA) & ~rx_empty;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(pdata[DATA_W-1:0]), .rdata(txData),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.W(DATA_W + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .wdata({rxFrmErr, rxParErr, rxData}), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign txStart = ctrl_q[CTRL_TX_EN] & ~tx_empty;

  // Sticky flags: a same-cycle event beats the W1C clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      irq_en_q <= '0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_q <= pdata[1:0];
      if (wr_ok && idx == REG_IRQ_EN && PSTRB[0]) irq_en_q <= pdata[IRQ_W-1:0];
      ovf_q <= (ovf_q & ~(stat_wr & pdata[IRQ_TX_OVF]))
             | (tx_push & tx_full & ~tx_pop);
      ovr_q <= (ovr_q & ~(stat_wr & pdata[IRQ_RX_OVR]))
             | (rx_push & rx_full & ~rx_pop);
      err_q <= (err_q & ~(stat_wr & pdata[IRQ_RX_ERR]))
             | (rx_push & (~rx_full | rx_pop) & (rxParErr | rxFrmErr));
    end
  end

  // tx_empty only counts as an interrupt source while the transmitter is
  // enabled, so IRQ_STAT reads back 0 straight out of reset.
  always_comb begin
    irq_stat                = '0;
    irq_stat[IRQ_TX_EMPTY]  = ctrl_q[CTRL_TX_EN] & tx_empty;
    irq_stat[IRQ_RX_THRESH] = (32'(rx_count) >= RX_THRESH);
    irq_stat[IRQ_TX_OVF]    = ovf_q;
    irq_stat[IRQ_RX_OVR]    = ovr_q;
    irq_stat[IRQ_RX_ERR]    = err_q;
  end

  assign irq = |(irq_stat & irq_en_q);

  always_comb begin
    prdata = '0;
    if (rd_ok && rst) begin
      case (idx)
        REG_RXDATA: begin
          if (!rx_empty) begin
            prdata[DATA_W-1:0] = rx_head[DATA_W-1:0];
            prdata[RX_PAR_BIT] = rx_head[DATA_W];
            prdata[RX_FRM_BIT] = rx_head[DATA_W+1];
          end
        end
        REG_STATUS: begin
          prdata[ST_TX_FULL]        = tx_full;
          prdata[ST_TX_EMPTY]       = tx_empty;
          prdata[ST_RX_FULL]        = rx_full;
          prdata[ST_RX_EMPTY]       = rx_empty;
          prdata[ST_TX_COUNT +: 8]  = 8'(tx_count);
          prdata[ST_RX_COUNT +: 8]  = 8'(rx_count);
        end
        REG_CTRL:     prdata[1:0]       = ctrl_q;
        REG_IRQ_STAT: prdata[IRQ_W-1:0] = irq_stat;
        REG_IRQ_EN:   prdata[IRQ_W-1:0] = irq_en_q;
        default:      prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_fifo_slave.sv
// tb_uart_apb_fifo_slave: scoreboard bench for uart_apb_fifo_slave.
// A queue-based reference model predicts every cycle's outputs; a monitor
// pops each prediction and compares it with the DUT.
module tb_uart_apb_fifo_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] padd, pdata, prdata;
  logic        psel, pen, pwr, PREADY, PSLVERR;
  logic [3:0]  PSTRB;
  logic        txStart, txAck, rxValid, rxParErr, rxFrmErr, irq;
  logic [7:0]  txData, rxData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_apb_fifo_slave #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .RX_THRESH(8)) dut (
    .clk(clk), .rst(rst), .padd(padd), .pdata(pdata), .psel(psel), .pen(pen),
    .pwr(pwr), .PSTRB(PSTRB), .prdata(prdata), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .txStart(txStart), .txData(txData), .txAck(txAck), .rxValid(rxValid),
    .rxData(rxData), .rxParErr(rxParErr), .rxFrmErr(rxFrmErr), .irq(irq)
  );

  typedef struct {
    bit        acc;
    bit [31:0] rdata;
    bit        slverr;
    bit        txs;
    bit [7:0]  txd;
    bit        irq;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit [7:0] m_tx[$];
  bit [9:0] m_rx[$];     // {frm, par, data}
  bit       m_tx_en, m_rx_en, m_ovf, m_ovr, m_err;
  bit [4:0] m_ien;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: predict this cycle's outputs, then advance to the state after the edge.
  always @(negedge clk) begin : model
    exp_t     e;
    int       idx;
    bit       acc, illegal, wr, lvl_te, lvl_rt;
    bit       tx_pop, tx_push, rx_pop, rx_push, set_ovf, set_ovr, set_err;
    bit [4:0] stat;
    bit [9:0] v;
    e = '{default: 0};
    if (!rst) begin
      m_tx.delete(); m_rx.delete();
      m_tx_en = 0; m_rx_en = 0; m_ovf = 0; m_ovr = 0; m_err = 0; m_ien = 0;
      exp_q.push_back(e);
    end else begin
      acc     = psel && pen;
      idx     = int'(padd[4:2]);
      illegal = (idx >= 6) || (pwr && (idx == 1 || idx == 2)) || (!pwr && idx == 0);
      lvl_te  = m_tx_en && (m_tx.size() == 0);
      lvl_rt  = m_rx.size() >= 8;
      stat    = {m_err, m_ovr, m_ovf, lvl_rt, lvl_te};
      e.acc    = acc;
      e.slverr = acc && illegal;
      if (acc && !pwr && !illegal) begin
        case (idx)
          1: if (m_rx.size() > 0) begin
               v = m_rx[0];
               e.rdata = v[7:0] + (v[8] ? 32'h1_0000 : 0) + (v[9] ? 32'h2_0000 : 0);
             end
          2: e.rdata = (m_tx.size() == 16 ? 1 : 0) + (m_tx.size() == 0 ? 2 : 0)
                     + (m_rx.size() == 16 ? 4 : 0) + (m_rx.size() == 0 ? 8 : 0)
                     + m_tx.size() * 256 + m_rx.size() * 65536;
          3: e.rdata = {30'b0, m_rx_en, m_tx_en};
          4: e.rdata = {27'b0, stat};
          5: e.rdata = {27'b0, m_ien};
          default: e.rdata = 0;
        endcase
      end
      e.txs = m_tx_en && (m_tx.size() > 0);
      e.txd = e.txs ? m_tx[0] : 8'h0;
      e.irq = |(stat & m_ien);
      exp_q.push_back(e);

      wr      = acc && pwr && !illegal;
      tx_pop  = txAck && e.txs;
      tx_push = wr && idx == 0 && PSTRB[0];
      rx_pop  = acc && !pwr && idx == 1 && m_rx.size() > 0;
      rx_push = rxValid && m_rx_en;
      set_ovf = tx_push && m_tx.size() == 16 && !tx_pop;
      set_ovr = rx_push && m_rx.size() == 16 && !rx_pop;
      set_err = rx_push && !set_ovr && (rxParErr || rxFrmErr);
      if (tx_pop) void'(m_tx.pop_front());
      if (tx_push && !set_ovf) m_tx.push_back(pdata[7:0]);
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_push && !set_ovr) m_rx.push_back({rxFrmErr, rxParErr, rxData});
      if (wr && idx == 3 && PSTRB[0]) begin
        m_tx_en = pdata[0];
        m_rx_en = pdata[1];
        if (pdata[2]) m_tx.delete();
        if (pdata[3]) m_rx.delete();
      end
      if (wr && idx == 4 && PSTRB[0]) begin
        if (pdata[2]) m_ovf = 0;
        if (pdata[3]) m_ovr = 0;
        if (pdata[4]) m_err = 0;
      end
      if (set_ovf) m_ovf = 1;
      if (set_ovr) m_ovr = 1;
      if (set_err) m_err = 1;
      if (wr && idx == 5 && PSTRB[0]) m_ien = pdata[4:0];
    end
  end

  // Monitor: compare the DUT against the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("PREADY", {31'b0, PREADY}, {31'b0, e.acc});
      chk("PSLVERR", {31'b0, PSLVERR}, {31'b0, e.slverr});
      chk("prdata", prdata, e.rdata);
      chk("txStart", {31'b0, txStart}, {31'b0, e.txs});
      if (e.txs) chk("txData", {24'b0, txData}, {24'b0, e.txd});
      chk("irq", {31'b0, irq}, {31'b0, e.irq});
    end
  end

  task automatic apb(input int idx, input bit wr, input logic [31:0] d,
                     input logic [3:0] strb = 4'hF, input bit with_rx = 0,
                     input logic [7:0] rd = 8'h0);
    @(posedge clk); #1;
    psel  = 1; pen = 0; pwr = wr; pdata = d; PSTRB = strb;
    padd  = ($urandom & ~32'h1C) | (32'(idx) << 2);
    @(posedge clk); #1;
    pen = 1;
    if (with_rx) begin rxValid = 1; rxData = rd; end
    @(posedge clk); #1;
    psel = 0; pen = 0; pwr = 0; rxValid = 0;
  endtask

  task automatic rx_pulse(input logic [7:0] d, input bit par, input bit frm);
    @(posedge clk); #1;
    rxValid = 1; rxData = d; rxParErr = par; rxFrmErr = frm;
    @(posedge clk); #1;
    rxValid = 0; rxParErr = 0; rxFrmErr = 0;
  endtask

  task automatic ack();
    @(posedge clk); #1 txAck = 1;
    @(posedge clk); #1 txAck = 0;
  endtask

  initial begin
    int r, idx;
    logic [31:0] d;
    logic [3:0]  s;
    rst = 0; psel = 0; pen = 0; pwr = 0; padd = 0; pdata = 0; PSTRB = 0;
    txAck = 0; rxValid = 0; rxData = 0; rxParErr = 0; rxFrmErr = 0;
    #23 rst = 1;

    // 1: two characters through the TX FIFO
    apb(3, 1, 32'h1);
    apb(0, 1, 32'h41);
    apb(0, 1, 32'h42);
    ack(); ack();
    apb(4, 0, 0);

    // 2: overfill TX with the transmitter disabled
    apb(3, 1, 32'h0);
    for (int i = 0; i < 17; i++) apb(0, 1, (i == 16) ? 32'h99 : 32'(8'h30 + i));
    apb(2, 0, 0);
    apb(4, 0, 0);
    apb(4, 1, 32'h4);
    apb(4, 0, 0);
    apb(3, 1, 32'h1);
    for (int i = 0; i < 17; i++) ack();

    // 3: RX threshold and error flag
    apb(3, 1, 32'h2);
    apb(5, 1, 32'h12);
    for (int i = 0; i < 8; i++) rx_pulse(8'(8'hA0 + i), i == 2, 0);
    apb(4, 0, 0);
    for (int i = 0; i < 3; i++) apb(1, 0, 0);
    apb(4, 0, 0);

    // 4: RX full with simultaneous read and push, then overrun
    apb(3, 1, 32'hA);
    for (int i = 0; i < 16; i++) rx_pulse(8'(i), 0, (i == 5));
    apb(1, 0, 0, 4'hF, 1, 8'hEE);
    apb(2, 0, 0);
    rx_pulse(8'h77, 0, 0);
    apb(4, 0, 0);
    apb(4, 1, 32'h1C);
    apb(4, 0, 0);

    // 5: strobe gating and bus errors
    apb(0, 1, 32'h55, 4'b0010);
    apb(2, 0, 0);
    apb(6, 0, 0);
    apb(7, 1, 32'hFFFF_FFFF);
    apb(0, 0, 0);
    apb(2, 1, 32'hFF);
    apb(1, 1, 32'hFF);

    // Random traffic
    apb(3, 1, 32'h3);
    apb(5, 1, 32'(($urandom & 32'h1F)));
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) rx_pulse(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      else if (r == 3) ack();
      else begin
        idx = $urandom_range(0, 7);
        d   = $urandom;
        s   = 4'hF;
        if (idx == 3) d = (d & 32'h3) | (($urandom_range(0, 7) == 0) ? 32'hC : 32'h0);
        if (idx == 0 && $urandom_range(0, 3) == 0) s = 4'($urandom);
        apb(idx, $urandom_range(0, 1) == 1, d, s, $urandom_range(0, 3) == 0, 8'($urandom));
      end
    end

    // 6: asynchronous reset mid-stream
    apb(3, 1, 32'hF);
    apb(5, 1, 32'h1F);
    apb(0, 1, 32'h5A);
    rx_pulse(8'h11, 1, 0);
    @(posedge clk); #1;
    chk("pre_reset_txStart", {31'b0, txStart}, 32'd1);
    chk("pre_reset_irq", {31'b0, irq}, 32'd1);
    #2 rst = 0;
    #1;
    chk("async_txStart", {31'b0, txStart}, 32'd0);
    chk("async_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    apb(2, 0, 0);
    apb(4, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
